// File: rtl/axi_slv_wch_arbiter.sv
// Write-data scheduler for one crossbar slave port.
// Grants are recorded in AW order and replayed one burst at a time on the
// slave W channel, so W beats never interleave and always follow AW order.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no burst selected; W outputs and all m_wready held at 0
//   ST_ACTIVE | burst of master cur_idx muxed onto the slave W channel
module axi_slv_wch_arbiter #(
   parameter int NUM_MST    = 3,
   parameter int AXI_ID_W   = 4,
   parameter int AXI_DATA_W = 32,
   parameter int OSTD_DEPTH = 4,
   localparam int IDX_W     = $clog2(NUM_MST),
   localparam int STRB_W    = AXI_DATA_W / 8
) (
   input  logic                          aclk,
   input  logic                          srst,
   input  logic                          aw_push,
   input  logic [IDX_W-1:0]              aw_push_idx,
   input  logic [3:0]                    aw_push_len,
   output logic                          aw_fifo_full,
   input  logic [NUM_MST-1:0]            m_wvalid,
   output logic [NUM_MST-1:0]            m_wready,
   input  logic [NUM_MST-1:0]            m_wlast,
   input  logic [NUM_MST*AXI_ID_W-1:0]   m_wid,
   input  logic [NUM_MST*AXI_DATA_W-1:0] m_wdata,
   input  logic [NUM_MST*STRB_W-1:0]     m_wstrb,
   output logic                          s_wvalid,
   input  logic                          s_wready,
   output logic                          s_wlast,
   output logic [AXI_ID_W-1:0]           s_wid,
   output logic [AXI_DATA_W-1:0]         s_wdata,
   output logic [STRB_W-1:0]             s_wstrb,
   output logic                          wlast_err
);

   localparam int PTR_W = $clog2(OSTD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] fifo_idx [OSTD_DEPTH];
   logic [3:0]       fifo_len [OSTD_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] cur_idx;
   logic [3:0]       cur_len;
   logic [3:0]       beat_cnt;

   logic sel_last;
   logic beat;
   logic pop;
   logic push_ok;

   assign aw_fifo_full = (count == CNT_W'(OSTD_DEPTH));

   // Select the current master's W channel; everything reads 0 when idle.
   always_comb begin
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
      s_wid    = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m_wready = '0;
      sel_last = 1'b0;
      if (state == ST_ACTIVE) begin
         for (int i = 0; i < NUM_MST; i++) begin
            if (cur_idx == IDX_W'(i)) begin
               s_wvalid    = m_wvalid[i];
               m_wready[i] = s_wready;
               s_wid       = m_wid[i*AXI_ID_W +: AXI_ID_W];
               s_wdata     = m_wdata[i*AXI_DATA_W +: AXI_DATA_W];
               s_wstrb     = m_wstrb[i*STRB_W +: STRB_W];
               sel_last    = m_wlast[i];
            end
         end
         s_wlast = (beat_cnt == cur_len);
      end
   end

   // Pop when idle with work queued, or on a final beat so the next burst
   // starts without a bubble. A pop frees a slot for a same-cycle push.
   always_comb begin
      beat    = s_wvalid && s_wready;
      pop     = (count != '0) && ((state == ST_IDLE) || (beat && s_wlast));
      push_ok = aw_push && (!aw_fifo_full || pop);
   end

   // Grant storage; contents are don't-care while their slot is empty.
   always_ff @(posedge aclk) begin
      if (push_ok) begin
         fifo_idx[wr_ptr] <= aw_push_idx;
         fifo_len[wr_ptr] <= aw_push_len;
      end
   end

   // Order FIFO pointers, burst tracking FSM and wlast checker.
   always_ff @(posedge aclk) begin
      if (srst) begin
         state     <= ST_IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         beat_cnt  <= '0;
         cur_idx   <= '0;
         cur_len   <= '0;
         wlast_err <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count + CNT_W'(push_ok) - CNT_W'(pop);
         wlast_err <= beat && (sel_last != s_wlast);
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  cur_idx  <= fifo_idx[rd_ptr];
                  cur_len  <= fifo_len[rd_ptr];
                  beat_cnt <= '0;
                  state    <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (beat) begin
                  if (!s_wlast) begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end else if (pop) begin
                     cur_idx  <= fifo_idx[rd_ptr];
                     cur_len  <= fifo_len[rd_ptr];
                     beat_cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_slv_wch_arbiter.sv
// Self-checking bench: queue-based reference model of the W scheduler,
// directed scenarios followed by randomized traffic.
module tb_axi_slv_wch_arbiter;

   localparam int NUM_MST = 3;
   localparam int ID_W    = 4;
   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;
   localparam int DEPTH   = 4;

   logic                       aclk = 1'b0;
   logic                       srst;
   logic                       aw_push;
   logic [1:0]                 aw_push_idx;
   logic [3:0]                 aw_push_len;
   logic                       aw_fifo_full;
   logic [NUM_MST-1:0]         m_wvalid;
   logic [NUM_MST-1:0]         m_wready;
   logic [NUM_MST-1:0]         m_wlast;
   logic [NUM_MST*ID_W-1:0]    m_wid;
   logic [NUM_MST*DATA_W-1:0]  m_wdata;
   logic [NUM_MST*STRB_W-1:0]  m_wstrb;
   logic                       s_wvalid;
   logic                       s_wready;
   logic                       s_wlast;
   logic [ID_W-1:0]            s_wid;
   logic [DATA_W-1:0]          s_wdata;
   logic [STRB_W-1:0]          s_wstrb;
   logic                       wlast_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 aclk = ~aclk;

   axi_slv_wch_arbiter #(
      .NUM_MST(NUM_MST), .AXI_ID_W(ID_W), .AXI_DATA_W(DATA_W), .OSTD_DEPTH(DEPTH)
   ) dut (
      .aclk(aclk), .srst(srst),
      .aw_push(aw_push), .aw_push_idx(aw_push_idx), .aw_push_len(aw_push_len),
      .aw_fifo_full(aw_fifo_full),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
      .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .wlast_err(wlast_err)
   );

   // reference model: pending grants, current burst, beats already done
   typedef struct { int idx; int len; } grant_t;
   grant_t q[$];
   grant_t cur;
   bit     m_active;
   int     m_done;
   bit     m_err;
   int     n_bursts;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 1'b0;
      m_done   = 0;
      m_err    = 1'b0;
      cur      = '{0, 0};
   endtask

   // apply the scheduling rules to the inputs present at this edge
   task automatic model_edge();
      bit     beat, last, pop, push_ok;
      grant_t head;
      if (srst) begin
         model_reset();
         return;
      end
      beat    = m_active && m_wvalid[cur.idx] && s_wready;
      last    = m_active && (m_done == cur.len);
      pop     = (q.size() > 0) && (!m_active || (beat && last));
      push_ok = aw_push && ((q.size() < DEPTH) || pop);
      m_err   = beat && (m_wlast[cur.idx] != last);
      head    = '{0, 0};
      if (pop) head = q.pop_front();
      if (push_ok) q.push_back('{int'(aw_push_idx), int'(aw_push_len)});
      if (beat && last) n_bursts++;
      if (!m_active) begin
         if (pop) begin
            m_active = 1'b1;
            cur      = head;
            m_done   = 0;
         end
      end else if (beat) begin
         if (!last) m_done++;
         else if (pop) begin
            cur    = head;
            m_done = 0;
         end else m_active = 1'b0;
      end
   endtask

   // compare every output against the model, then advance one clock
   task automatic cycle();
      logic [NUM_MST-1:0] exp_rdy;
      #1;
      exp_rdy = '0;
      if (m_active) exp_rdy[cur.idx] = s_wready;
      chk("full",     64'(aw_fifo_full), 64'(q.size() == DEPTH));
      chk("s_wvalid", 64'(s_wvalid), 64'(m_active ? m_wvalid[cur.idx] : 1'b0));
      chk("m_wready", 64'(m_wready), 64'(exp_rdy));
      chk("s_wlast",  64'(s_wlast),  64'(m_active && (m_done == cur.len)));
      chk("s_wdata",  64'(s_wdata),  m_active ? 64'(m_wdata[cur.idx*DATA_W +: DATA_W]) : 64'd0);
      chk("s_wid",    64'(s_wid),    m_active ? 64'(m_wid[cur.idx*ID_W +: ID_W]) : 64'd0);
      chk("s_wstrb",  64'(s_wstrb),  m_active ? 64'(m_wstrb[cur.idx*STRB_W +: STRB_W]) : 64'd0);
      chk("wlast_err", 64'(wlast_err), 64'(m_err));
      @(posedge aclk);
      model_edge();
      #1;
   endtask

   task automatic rand_payload();
      m_wdata = {$urandom, $urandom, $urandom};
      m_wid   = 12'($urandom);
      m_wstrb = 12'($urandom);
   endtask

   // master wlast agrees with awlen unless a corruption is requested
   task automatic drive_wlast(input bit corrupt);
      m_wlast = 3'($urandom);
      if (m_active) m_wlast[cur.idx] = (m_done == cur.len) ^ corrupt;
   endtask

   task automatic idle_inputs();
      aw_push = 1'b0; aw_push_idx = '0; aw_push_len = '0;
      m_wvalid = '0; m_wlast = '0; s_wready = 1'b0;
   endtask

   initial begin
      n_bursts = 0;
      idle_inputs();
      rand_payload();
      srst = 1'b1;
      model_reset();
      @(posedge aclk);
      #1;
      cycle();
      srst = 1'b0;

      // single burst m1 len3, and two back-to-back bursts m2 len1 / m0 len0
      aw_push = 1'b1; aw_push_idx = 2'd1; aw_push_len = 4'd3;
      m_wvalid = 3'b010; s_wready = 1'b1;
      cycle();
      aw_push = 1'b0;
      for (int i = 0; i < 8; i++) begin rand_payload(); drive_wlast(0); cycle(); end
      m_wvalid = 3'b111;
      aw_push = 1'b1; aw_push_idx = 2'd2; aw_push_len = 4'd1; cycle();
      aw_push_idx = 2'd0; aw_push_len = 4'd0; cycle();
      aw_push = 1'b0;
      for (int i = 0; i < 6; i++) begin rand_payload(); drive_wlast(0); cycle(); end

      // throttled slave ready, and a wlast that arrives early
      aw_push = 1'b1; aw_push_idx = 2'd1; aw_push_len = 4'd3; cycle();
      aw_push_idx = 2'd0; aw_push_len = 4'd2; cycle();
      aw_push = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_wready = i[0];
         drive_wlast(m_active && cur.idx == 0 && m_done == 1);
         cycle();
      end

      // fill the order FIFO with no W traffic, overflow, then drain
      m_wvalid = '0; s_wready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         aw_push = 1'b1; aw_push_idx = 2'(i % NUM_MST); aw_push_len = 4'(i % 3);
         cycle();
      end
      aw_push = 1'b0;
      m_wvalid = 3'b111;
      for (int i = 0; i < 20; i++) begin rand_payload(); drive_wlast(0); cycle(); end

      // reset mid-burst with grants queued, then replay
      aw_push = 1'b1; aw_push_idx = 2'd2; aw_push_len = 4'd3; cycle();
      aw_push_idx = 2'd0; cycle();
      aw_push_idx = 2'd1; cycle();
      aw_push = 1'b0;
      for (int i = 0; i < 2; i++) begin drive_wlast(0); cycle(); end
      srst = 1'b1; cycle();
      srst = 1'b0; cycle();
      aw_push = 1'b1; aw_push_idx = 2'd1; aw_push_len = 4'd0; cycle();
      aw_push = 1'b0;
      for (int i = 0; i < 4; i++) begin drive_wlast(0); cycle(); end

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         srst        = ($urandom_range(0, 499) == 0);
         aw_push     = ($urandom_range(0, 3) == 0);
         aw_push_idx = 2'($urandom_range(0, NUM_MST-1));
         aw_push_len = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
         m_wvalid    = 3'($urandom);
         if ($urandom_range(0, 3) != 0) m_wvalid = m_wvalid | 3'b111;
         s_wready    = ($urandom_range(0, 3) != 0);
         rand_payload();
         drive_wlast($urandom_range(0, 15) == 0);
         cycle();
      end
      srst = 1'b0;
      idle_inputs();
      cycle();

      chk("bursts_done", 64'(n_bursts > 50), 64'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
